cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Memory-side responder for the L2/arbiter line protocol (read, write, addr, wdata, rdata, resp).
- Accepts one full cache line request at a time and converts it into a burst of narrower beats on the physical memory bus.
- For reads, collects the returned beats into a line. For writes, splits the line into beats.
- Sits between the L2 cache's lower port and main memory; one outstanding request, no reordering.

Parameters:
- LWIDTH, 256, line width in bits; must be BWIDTH times a power of two.
- BWIDTH, 64, memory bus beat width in bits.
- BEATS, LWIDTH/BWIDTH (derived localparam, 4), beats per line.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- line_read  in  1  line read request, held until line_resp
- line_write  in  1  line write request, held until line_resp
- line_addr  in  32  line byte address
- line_wdata  in  LWIDTH  write line, stable while line_write high
- line_rdata  out  LWIDTH  assembled read line
- line_resp  out  1  one-cycle completion pulse
- mem_read  out  1  memory burst read
- mem_write  out  1  memory burst write
- mem_addr  out  32  line-aligned burst address
- mem_wdata  out  BWIDTH  current write beat
- mem_rdata  in  BWIDTH  current read beat
- mem_resp  in  1  one beat accepted/valid this cycle

Behaviour:
- Reset (clk edge with rst=1):
  - FSM goes to IDLE; beat counter = 0.
  - All outputs = 0, including line_rdata.
  - rst mid-burst abandons the burst. mem_read/mem_write drop the next cycle and no line_resp is issued.
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - If line_write=1, latch line_addr (low log2(LWIDTH/8) bits forced 0) and line_wdata, then go to WR_BURST.
  - Else if line_read=1, latch the address and go to RD_BURST.
  - If both are high, the write wins and the read is ignored for this transaction.
- RD_BURST:
  - mem_read=1 and mem_addr=latched address for the whole state.
  - On each cycle with mem_resp=1, write mem_rdata into slice [cnt*BWIDTH +: BWIDTH] of the line buffer and increment cnt.
  - mem_resp may have gap cycles; cnt holds during gaps.
  - On the beat where cnt=BEATS-1, go to DONE.
- WR_BURST:
  - mem_write=1 and mem_addr=latched address.
  - mem_wdata = latched line slice cnt, combinationally from cnt.
  - Each mem_resp increments cnt; on the last beat go to DONE.
- DONE:
  - line_resp=1 for exactly one cycle; cnt resets to 0; next state is IDLE.
  - mem_read and mem_write are 0 in DONE.
- line_rdata is the registered line buffer.
  - It updates only during RD_BURST beats.
  - It is valid in the line_resp cycle and holds until the next read's first beat.
- Latency with no mem gaps:
  - Request seen in IDLE at cycle 0.
  - Burst at cycles 1..BEATS.
  - line_resp at cycle BEATS+1.
- Requester must drop line_read/line_write in the cycle after line_resp; the arbiter's resp_reg enforces this.
- A request still high in IDLE after DONE starts a new transaction; this is not an error.
- line_addr/line_wdata changes after latching are ignored.
- mem_resp in IDLE or DONE is ignored.
- cnt is log2(BEATS) bits and wraps to 0 only via DONE or rst.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_PERF_EN.
- When defined, adds two ports: rd_lines out 32 and wr_lines out 32.
  - Each is a saturating counter incremented in DONE for read/write transactions respectively.
  - Cleared by rst; holds at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist. Core behaviour is identical in both builds.

Decomposition:
- Package cacheline_adaptor_pkg holds:
  - the state enum (adaptor_state_t: IDLE, RD_BURST, WR_BURST, DONE);
  - localparams LWIDTH_DEF=256, BWIDTH_DEF=64;
  - the offset-bit constant.
- Optional sub-module line_shift_buf holds the LWIDTH register with beat-indexed write and beat-indexed read mux, parameterised by LWIDTH/BWIDTH. The FSM and counter stay in the top module.

Test Plan:
- Read, no gaps:
  - Stimulus: line_read=1, line_addr=32'h0000_1234; mem_resp high 4 cycles with beats 64'hA0, 64'hA1, 64'hA2, 64'hA3.
  - Response: mem_addr=32'h0000_1220; line_resp one cycle later; line_rdata={A3,A2,A1,A0}.
- Write, gapped:
  - Stimulus: line_write=1, line_wdata={D3,D2,D1,D0}; mem_resp pattern 1,0,0,1,1,0,1.
  - Response: mem_wdata sequence D0,D1,D2,D3 advancing only on resp cycles; line_resp after the 4th beat; mem_write=0 in DONE.
- Simultaneous request:
  - Stimulus: line_read=1 and line_write=1 in IDLE.
  - Response: only mem_write asserted; mem_read stays 0 throughout.
- Mid-burst reset:
  - Stimulus: rst after 2 read beats.
  - Response: next cycle mem_read=0, line_resp never pulses, line_rdata=0; a following read completes correctly.
- Back-to-back:
  - Stimulus: line_read held high 1 cycle past line_resp.
  - Response: a second full burst is issued; exactly one line_resp per burst.
- PERF build:
  - Stimulus: 3 reads then 2 writes.
  - Response: rd_lines=3, wr_lines=2; both 0 after rst.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_adaptor_pkg
//  Description : Shared types and constants for the cache-line to memory-beat
//                adaptor: FSM state encoding, default widths and the line
//                address alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cacheline_adaptor_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adaptor_state_t;

    localparam int LWIDTH_DEF = 256;
    localparam int BWIDTH_DEF = 64;

    // Byte-offset bits inside a default-width line (5 for 256-bit lines).
    localparam int LINE_OFFSET_BITS = $clog2(LWIDTH_DEF / 8);

    // Force the byte-offset bits of an address to zero.
    function automatic logic [31:0] line_align(input logic [31:0] addr,
                                               input int unsigned off_bits);
        return (addr >> off_bits) << off_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cacheline_adaptor_line_shift_buf.sv
`default_nettype none
// ============================================================================
//  Module      : line_shift_buf
//  Description : LWIDTH-bit line register with a full-line load port, a
//                beat-indexed write port and a beat-indexed read mux.
//                Full-line load takes priority over a beat write.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_shift_buf #(
    parameter int LWIDTH = 256,
    parameter int BWIDTH = 64,
    parameter int IDX_W  = ((LWIDTH / BWIDTH) > 1) ? $clog2(LWIDTH / BWIDTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [LWIDTH-1:0] load_data,
    input  logic              beat_we,
    input  logic [IDX_W-1:0]  beat_idx,
    input  logic [BWIDTH-1:0] beat_wdata,
    output logic [LWIDTH-1:0] line_q,
    output logic [BWIDTH-1:0] beat_rdata
);

    logic [LWIDTH-1:0] line_d;

    // Next line value: whole-line load, or replace the addressed beat slice.
    always_comb begin
        line_d = line_q;
        if (load_en) begin
            line_d = load_data;
        end else if (beat_we) begin
            line_d[beat_idx*BWIDTH +: BWIDTH] = beat_wdata;
        end
    end

    // Line storage, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign beat_rdata = line_q[beat_idx*BWIDTH +: BWIDTH];

endmodule
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_adaptor
//  Description : Converts one full cache-line read/write request into a burst
//                of BWIDTH-bit beats on the memory bus. Reads are assembled
//                into line_rdata, writes are split into beats on mem_wdata.
//                One request outstanding; write wins over a simultaneous read.
//                Optional: define CACHELINE_ADAPTOR_PERF_EN to add saturating
//                rd_lines / wr_lines transaction counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int LWIDTH = LWIDTH_DEF,
    parameter int BWIDTH = BWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_addr,
    input  logic [LWIDTH-1:0] line_wdata,
    output logic [LWIDTH-1:0] line_rdata,
    output logic              line_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [BWIDTH-1:0] mem_wdata,
    input  logic [BWIDTH-1:0] mem_rdata,
    input  logic              mem_resp
`ifdef CACHELINE_ADAPTOR_PERF_EN
    ,
    output logic [31:0]       rd_lines,
    output logic [31:0]       wr_lines
`endif
);

    localparam int BEATS = LWIDTH / BWIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LWIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adaptor_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              wr_load;
    logic              rd_beat_we;

    // Outputs of the two line buffers that this block does not need.
    logic [BWIDTH-1:0] rd_beat_unused;
    logic [LWIDTH-1:0] wr_line_unused;

    // Next-state, beat counter and memory-bus strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_load    = 1'b0;
        rd_beat_we = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        line_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (line_write) begin
                    addr_d  = line_align(line_addr, OFF_W);
                    wr_load = 1'b1;
                    state_d = WR_BURST;
                end else if (line_read) begin
                    addr_d  = line_align(line_addr, OFF_W);
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    rd_beat_we = 1'b1;
                    // Counter never wraps inside a burst; DONE clears it.
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WR_BURST: begin
                mem_write = 1'b1;
                if (mem_resp) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                line_resp = 1'b1;
                cnt_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, beat counter and latched line address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    assign mem_addr = addr_q;

    // Read assembly buffer: beats land in slice cnt, whole line drives line_rdata.
    line_shift_buf #(
        .LWIDTH (LWIDTH),
        .BWIDTH (BWIDTH),
        .IDX_W  (CNT_W)
    ) u_rd_buf (
        .clk        (clk),
        .rst        (rst),
        .load_en    (1'b0),
        .load_data  ({LWIDTH{1'b0}}),
        .beat_we    (rd_beat_we),
        .beat_idx   (cnt_q),
        .beat_wdata (mem_rdata),
        .line_q     (line_rdata),
        .beat_rdata (rd_beat_unused)
    );

    // Write line buffer: loaded once at request, slice cnt drives mem_wdata.
    line_shift_buf #(
        .LWIDTH (LWIDTH),
        .BWIDTH (BWIDTH),
        .IDX_W  (CNT_W)
    ) u_wr_buf (
        .clk        (clk),
        .rst        (rst),
        .load_en    (wr_load),
        .load_data  (line_wdata),
        .beat_we    (1'b0),
        .beat_idx   (cnt_q),
        .beat_wdata ({BWIDTH{1'b0}}),
        .line_q     (wr_line_unused),
        .beat_rdata (mem_wdata)
    );

`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic        op_wr_q, op_wr_d;
    logic [31:0] rd_lines_q, rd_lines_d;
    logic [31:0] wr_lines_q, wr_lines_d;

    // Saturating per-direction completion counters, bumped in DONE.
    always_comb begin
        op_wr_d    = op_wr_q;
        rd_lines_d = rd_lines_q;
        wr_lines_d = wr_lines_q;
        if (state_q == IDLE && (line_write || line_read)) begin
            op_wr_d = line_write;
        end
        if (state_q == DONE) begin
            if (op_wr_q) begin
                if (wr_lines_q != 32'hFFFF_FFFF) wr_lines_d = wr_lines_q + 32'd1;
            end else begin
                if (rd_lines_q != 32'hFFFF_FFFF) rd_lines_d = rd_lines_q + 32'd1;
            end
        end
    end

    // Counter and transaction-direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr_q    <= 1'b0;
            rd_lines_q <= '0;
            wr_lines_q <= '0;
        end else begin
            op_wr_q    <= op_wr_d;
            rd_lines_q <= rd_lines_d;
            wr_lines_q <= wr_lines_d;
        end
    end

    assign rd_lines = rd_lines_q;
    assign wr_lines = wr_lines_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cacheline_adaptor
//  Description : Self-checking bench for cacheline_adaptor with a randomised
//                memory responder and a line-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int NB = LW / BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          line_read, line_write;
    logic [31:0]   line_addr;
    logic [LW-1:0] line_wdata, line_rdata;
    logic          line_resp;
    logic          mem_read, mem_write;
    logic [31:0]   mem_addr;
    logic [BW-1:0] mem_wdata, mem_rdata;
    logic          mem_resp;
`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic [31:0]   rd_lines, wr_lines;
`endif

    cacheline_adaptor #(.LWIDTH(LW), .BWIDTH(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_read  (line_read),
        .line_write (line_write),
        .line_addr  (line_addr),
        .line_wdata (line_wdata),
        .line_rdata (line_rdata),
        .line_resp  (line_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
`ifdef CACHELINE_ADAPTOR_PERF_EN
        ,
        .rd_lines   (rd_lines),
        .wr_lines   (wr_lines)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: line_rdata holds the last completed read line.
    logic [LW-1:0] exp_rline;

    // Observations gathered by the responder.
    logic [BW-1:0] rbeat_src[$];
    int            resp_pat[$];
    logic [BW-1:0] obs_wbeats[$];
    logic [BW-1:0] obs_wall[$];
    logic [31:0]   obs_addr[$];
    logic [LW-1:0] obs_rdata[$];
    int            obs_resp_cnt, obs_lat, obs_rd_seen, obs_wr_seen, obs_bursts, obs_busy_at_resp;

    function automatic logic [BW-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; line_read = 1'b0; line_write = 1'b0; mem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rline = '0;
    endtask

    // Memory responder: drives one request and services the bursts it causes.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [LW-1:0] wdata, input int gap_pct, input int n_txn);
        logic busy, prev_busy, go;
        int   quiet;
        obs_wbeats.delete(); obs_wall.delete(); obs_addr.delete(); obs_rdata.delete();
        obs_resp_cnt = 0; obs_lat = -1; obs_rd_seen = 0; obs_wr_seen = 0;
        obs_bursts = 0; obs_busy_at_resp = 0;
        @(negedge clk);
        line_read = rd; line_write = wr; line_addr = addr; line_wdata = wdata; mem_resp = 1'b0;
        prev_busy = 1'b0; quiet = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            mem_resp  = 1'b0;
            mem_rdata = rand64();
            busy = mem_read | mem_write;
            if (mem_read)  obs_rd_seen++;
            if (mem_write) begin obs_wr_seen++; obs_wall.push_back(mem_wdata); end
            if (busy && !prev_busy) obs_bursts++;
            prev_busy = busy;
            if (busy) obs_addr.push_back(mem_addr);
            if (line_resp) begin
                obs_resp_cnt++;
                if (obs_resp_cnt == 1) obs_lat = cyc;
                obs_rdata.push_back(line_rdata);
                if (busy) obs_busy_at_resp++;
                if (obs_resp_cnt == n_txn) begin
                    line_read = 1'b0; line_write = 1'b0; quiet = 8;
                end
            end
            if (busy) begin
                if (resp_pat.size() > 0) go = (resp_pat.pop_front() != 0);
                else go = ($urandom_range(99) >= gap_pct);
                if (go) begin
                    mem_resp = 1'b1;
                    if (mem_read) begin
                        if (rbeat_src.size() > 0) mem_rdata = rbeat_src.pop_front();
                    end else begin
                        obs_wbeats.push_back(mem_wdata);
                    end
                end
            end else if (gap_pct > 0 && $urandom_range(1) == 1) begin
                mem_resp = 1'b1;   // stray response outside a burst
            end
            if (quiet > 0) begin
                quiet--;
                if (quiet == 0) break;
            end
        end
        line_read = 1'b0; line_write = 1'b0; mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        if (line_rdata !== '0) begin n_bad++; $display("FAIL reset_line_rdata: got %0h want 0", line_rdata); end
        n_cmp++;
        if ({line_resp, mem_read, mem_write} !== 3'b000) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 000", {line_resp, mem_read, mem_write});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== '0) begin
            n_bad++; $display("FAIL reset_mem_bus: got addr %0h wdata %0h want 0", mem_addr, mem_wdata);
        end
        n_cmp++;
    endtask

    task automatic test_read_nogap();
        logic [LW-1:0] exp;
        rbeat_src = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
        exp = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        do_txn(1'b1, 1'b0, 32'h0000_1234, '0, 0, 1);
        if (obs_resp_cnt !== 1) begin n_bad++; $display("FAIL rd_resp_count: got %0d want 1", obs_resp_cnt); end
        n_cmp++;
        if (obs_lat !== NB + 1) begin n_bad++; $display("FAIL rd_latency: got %0d want %0d", obs_lat, NB + 1); end
        n_cmp++;
        if (obs_rdata.size() != 1 || obs_rdata[0] !== exp) begin
            n_bad++; $display("FAIL rd_line: got %0h want %0h", (obs_rdata.size() > 0) ? obs_rdata[0] : '0, exp);
        end
        n_cmp++;
        if (obs_addr.size() != NB) begin n_bad++; $display("FAIL rd_burst_len: got %0d want %0d", obs_addr.size(), NB); end
        n_cmp++;
        foreach (obs_addr[i]) begin
            if (obs_addr[i] !== 32'h0000_1220) begin
                n_bad++; $display("FAIL rd_mem_addr[%0d]: got %0h want 1220", i, obs_addr[i]);
            end
            n_cmp++;
        end
        if (obs_wr_seen !== 0 || obs_busy_at_resp !== 0) begin
            n_bad++; $display("FAIL rd_strobes: got wr_seen %0d busy_at_resp %0d want 0 0", obs_wr_seen, obs_busy_at_resp);
        end
        n_cmp++;
        exp_rline = exp;
    endtask

    task automatic test_write_gapped();
        logic [LW-1:0] wd;
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int k;
        wd = rand_line();
        resp_pat.delete();
        foreach (pat[i]) resp_pat.push_back(pat[i]);
        do_txn(1'b0, 1'b1, 32'hDEAD_BEEF, wd, 0, 1);
        if (obs_wall.size() != 7) begin n_bad++; $display("FAIL wr_cycles: got %0d want 7", obs_wall.size()); end
        n_cmp++;
        k = 0;
        foreach (pat[i]) begin
            if (i < obs_wall.size()) begin
                if (obs_wall[i] !== wd[k*BW +: BW]) begin
                    n_bad++; $display("FAIL wr_wdata[%0d]: got %0h want %0h", i, obs_wall[i], wd[k*BW +: BW]);
                end
                n_cmp++;
            end
            if (pat[i] != 0) k++;
        end
        if (obs_lat !== 8 || obs_resp_cnt !== 1) begin
            n_bad++; $display("FAIL wr_resp: got lat %0d count %0d want 8 1", obs_lat, obs_resp_cnt);
        end
        n_cmp++;
        if (obs_busy_at_resp !== 0 || obs_rd_seen !== 0) begin
            n_bad++; $display("FAIL wr_strobes: got busy_at_resp %0d rd_seen %0d want 0 0", obs_busy_at_resp, obs_rd_seen);
        end
        n_cmp++;
        if (obs_addr.size() > 0 && obs_addr[0] !== 32'hDEAD_BEE0) begin
            n_bad++; $display("FAIL wr_mem_addr: got %0h want deadbee0", obs_addr[0]);
        end
        n_cmp++;
        if (obs_rdata.size() > 0 && obs_rdata[0] !== exp_rline) begin
            n_bad++; $display("FAIL wr_rdata_hold: got %0h want %0h", obs_rdata[0], exp_rline);
        end
        n_cmp++;
    endtask

    task automatic test_simultaneous();
        logic [LW-1:0] wd;
        wd = rand_line();
        do_txn(1'b1, 1'b1, $urandom, wd, 40, 1);
        if (obs_rd_seen !== 0) begin n_bad++; $display("FAIL sim_mem_read: got %0d cycles want 0", obs_rd_seen); end
        n_cmp++;
        if (obs_wbeats.size() != NB || obs_resp_cnt !== 1) begin
            n_bad++; $display("FAIL sim_write: got beats %0d resp %0d want %0d 1", obs_wbeats.size(), obs_resp_cnt, NB);
        end
        n_cmp++;
        foreach (obs_wbeats[i]) begin
            if (i < NB && obs_wbeats[i] !== wd[i*BW +: BW]) begin
                n_bad++; $display("FAIL sim_beat[%0d]: got %0h want %0h", i, obs_wbeats[i], wd[i*BW +: BW]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_midburst_reset();
        logic [BW-1:0] b[2];
        int given, resp_seen;
        b[0] = rand64(); b[1] = rand64();
        @(negedge clk);
        line_read = 1'b1; line_addr = $urandom; mem_resp = 1'b0;
        given = 0;
        for (int cyc = 0; cyc < 20 && given < 2; cyc++) begin
            @(negedge clk);
            mem_resp = 1'b0;
            if (mem_read) begin mem_resp = 1'b1; mem_rdata = b[given]; given++; end
        end
        @(negedge clk);
        mem_resp = 1'b0;
        if (mem_read !== 1'b1 || given !== 2) begin
            n_bad++; $display("FAIL mr_burst_active: got mem_read %b beats %0d want 1 2", mem_read, given);
        end
        n_cmp++;
        rst = 1'b1; line_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        if ({mem_read, mem_write} !== 2'b00 || line_rdata !== '0) begin
            n_bad++; $display("FAIL mr_after_reset: got rd %b wr %b line %0h want 0 0 0", mem_read, mem_write, line_rdata);
        end
        n_cmp++;
        resp_seen = (line_resp === 1'b1) ? 1 : 0;
        repeat (8) begin
            @(negedge clk);
            if (line_resp === 1'b1) resp_seen++;
        end
        if (resp_seen !== 0) begin n_bad++; $display("FAIL mr_no_resp: got %0d pulses want 0", resp_seen); end
        n_cmp++;
        exp_rline = '0;
        for (int i = 0; i < NB; i++) rbeat_src.push_back(rand64());
        begin
            logic [LW-1:0] exp;
            foreach (rbeat_src[i]) exp[i*BW +: BW] = rbeat_src[i];
            do_txn(1'b1, 1'b0, $urandom, '0, 30, 1);
            if (obs_rdata.size() != 1 || obs_rdata[0] !== exp) begin
                n_bad++; $display("FAIL mr_followup: got %0h want %0h", (obs_rdata.size() > 0) ? obs_rdata[0] : '0, exp);
            end
            n_cmp++;
            exp_rline = exp;
        end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] e0, e1;
        for (int i = 0; i < 2 * NB; i++) rbeat_src.push_back(rand64());
        for (int i = 0; i < NB; i++) begin
            e0[i*BW +: BW] = rbeat_src[i];
            e1[i*BW +: BW] = rbeat_src[NB + i];
        end
        do_txn(1'b1, 1'b0, 32'h0000_4000, '0, 25, 2);
        if (obs_resp_cnt !== 2 || obs_bursts !== 2) begin
            n_bad++; $display("FAIL b2b_counts: got resp %0d bursts %0d want 2 2", obs_resp_cnt, obs_bursts);
        end
        n_cmp++;
        if (obs_rdata.size() == 2) begin
            if (obs_rdata[0] !== e0 || obs_rdata[1] !== e1) begin
                n_bad++; $display("FAIL b2b_lines: got %0h / %0h want %0h / %0h", obs_rdata[0], obs_rdata[1], e0, e1);
            end
            n_cmp++;
        end
        exp_rline = e1;
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            logic          is_wr;
            logic [31:0]   a;
            logic [LW-1:0] wd, exp;
            int            gap;
            is_wr = $urandom_range(1);
            a     = $urandom;
            wd    = rand_line();
            gap   = $urandom_range(60);
            if (!is_wr) begin
                for (int i = 0; i < NB; i++) begin
                    exp[i*BW +: BW] = rand64();
                    rbeat_src.push_back(exp[i*BW +: BW]);
                end
            end else begin
                exp = exp_rline;
            end
            do_txn(!is_wr, is_wr, a, wd, gap, 1);
            if (obs_resp_cnt !== 1 || obs_bursts !== 1) begin
                n_bad++; $display("FAIL rnd%0d_counts: got resp %0d bursts %0d want 1 1", t, obs_resp_cnt, obs_bursts);
            end
            n_cmp++;
            if (obs_rdata.size() != 1 || obs_rdata[0] !== exp) begin
                n_bad++; $display("FAIL rnd%0d_rdata: got %0h want %0h", t, (obs_rdata.size() > 0) ? obs_rdata[0] : '0, exp);
            end
            n_cmp++;
            if (obs_addr.size() > 0 && obs_addr[0] !== {a[31:5], 5'b0}) begin
                n_bad++; $display("FAIL rnd%0d_addr: got %0h want %0h", t, obs_addr[0], {a[31:5], 5'b0});
            end
            n_cmp++;
            if (is_wr) begin
                for (int i = 0; i < NB; i++) begin
                    if (i >= obs_wbeats.size() || obs_wbeats[i] !== wd[i*BW +: BW]) begin
                        n_bad++; $display("FAIL rnd%0d_wbeat%0d: got %0h want %0h", t, i,
                                          (i < obs_wbeats.size()) ? obs_wbeats[i] : '0, wd[i*BW +: BW]);
                    end
                    n_cmp++;
                end
            end
            exp_rline = exp;
        end
    endtask

`ifdef CACHELINE_ADAPTOR_PERF_EN
    task automatic test_perf();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < NB; j++) rbeat_src.push_back(rand64());
            do_txn(1'b1, 1'b0, $urandom, '0, 20, 1);
        end
        for (int i = 0; i < 2; i++) do_txn(1'b0, 1'b1, $urandom, rand_line(), 20, 1);
        @(negedge clk);
        if (rd_lines !== 32'd3 || wr_lines !== 32'd2) begin
            n_bad++; $display("FAIL perf_counts: got rd %0d wr %0d want 3 2", rd_lines, wr_lines);
        end
        n_cmp++;
        apply_reset();
        @(negedge clk);
        if (rd_lines !== 32'd0 || wr_lines !== 32'd0) begin
            n_bad++; $display("FAIL perf_reset: got rd %0d wr %0d want 0 0", rd_lines, wr_lines);
        end
        n_cmp++;
    endtask
`endif

    initial begin
        rst = 1'b1; line_read = 1'b0; line_write = 1'b0; line_addr = '0;
        line_wdata = '0; mem_rdata = '0; mem_resp = 1'b0; exp_rline = '0;
        test_reset();
        test_read_nogap();
        test_write_gapped();
        test_simultaneous();
        test_midburst_reset();
        test_back_to_back();
        test_random();
`ifdef CACHELINE_ADAPTOR_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
